// File: rtl/cpu_i2c_target_if.sv
// Register-window port between the I2C target and the CPU-side register bank.
// The target owns the pointer and write strobe; the bank returns read data.
interface cpu_i2c_target_if #(
  parameter int PTR_WIDTH = 8
) ();
  logic [PTR_WIDTH-1:0] reg_address;
  logic [7:0]           reg_wdata;
  logic                 reg_write;
  logic [7:0]           reg_rdata;
  logic                 busy;

  modport master (
    output reg_address, reg_wdata, reg_write, busy,
    input  reg_rdata
  );

  modport slave (
    input  reg_address, reg_wdata, reg_write, busy,
    output reg_rdata
  );
endinterface

// File: rtl/cpu_i2c_target.sv
// I2C target answering one 7-bit address and bridging bytes to a CPU register
// window: first written byte sets the pointer, later bytes are written/read at it.
module cpu_i2c_target #(
  parameter logic [6:0] ADDRESS   = 7'h50,
  parameter int         PTR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i2c_scl,
  inout  wire              i2c_sda,
  cpu_i2c_target_if.master reg_if
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_e;

  logic [2:0]           scl_sync_q, scl_sync_d;
  logic [2:0]           sda_sync_q, sda_sync_d;
  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [6:0]           shift_q, shift_d;
  logic                 sda_oe_q, sda_oe_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic                 busy_q, busy_d;
  logic                 first_q, first_d;
  logic                 inc_q, inc_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Bits [1:0] form the synchronizer; bit 2 is the previous value for edge detection.
  assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
  assign start_det =  scl_sync_q[1] &  scl_sync_q[2] &  sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det  =  scl_sync_q[1] &  scl_sync_q[2] & ~sda_sync_q[2] &  sda_sync_q[1];
  assign rx_byte   = {shift_q, sda_sync_q[1]};

  assign i2c_sda            = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_if.reg_address = ptr_q;
  assign reg_if.reg_wdata   = wdata_q;
  assign reg_if.reg_write   = wr_q;
  assign reg_if.busy        = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      sda_oe_q   <= 1'b0;
      ptr_q      <= '0;
      wdata_q    <= 8'd0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      inc_q      <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      first_q    <= first_d;
      inc_q      <= inc_d;
    end
  end

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], i2c_scl};
    sda_sync_d = {sda_sync_q[1:0], i2c_sda};
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    ptr_d      = ptr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    busy_d     = busy_q;
    first_d    = first_q;
    inc_d      = inc_q;

    if (stop_det || start_det) begin
      state_d  = stop_det ? IDLE : ADDR;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      inc_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (cnt_q == 3'd7) begin
              cnt_d = 3'd0;
              if (shift_q == ADDRESS) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        // cnt 0 waits for the 8th falling edge to start the ACK, cnt 1 for the 9th to end it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b1;
              cnt_d    = 3'd1;
            end else begin
              cnt_d = 3'd0;
              if (shift_q[0]) begin
                shift_d  = reg_if.reg_rdata[6:0];
                sda_oe_d = ~reg_if.reg_rdata[7];
                state_d  = READ;
              end else begin
                sda_oe_d = 1'b0;
                first_d  = 1'b1;
                state_d  = WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              state_d = WRITE_ACK;
              if (first_q) begin
                ptr_d   = PTR_WIDTH'(rx_byte);
                first_d = 1'b0;
                inc_d   = 1'b0;
              end else begin
                wdata_d = rx_byte;
                wr_d    = 1'b1;
                inc_d   = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b1;
              cnt_d    = 3'd1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              state_d  = WRITE;
              if (inc_q) begin
                ptr_d = ptr_q + PTR_WIDTH'(1);
                inc_d = 1'b0;
              end
            end
          end
        end
        // Bit 7 is already on the bus on entry; each falling edge presents the next one.
        READ: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              cnt_d    = 3'd0;
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + PTR_WIDTH'(1);
              state_d  = READ_ACK;
            end else begin
              cnt_d    = cnt_q + 3'd1;
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[5:0], 1'b0};
            end
          end
        end
        READ_ACK: begin
          if (scl_rise && sda_sync_q[1]) begin
            state_d = IGNORE;
          end else if (scl_fall) begin
            shift_d  = reg_if.reg_rdata[6:0];
            sda_oe_d = ~reg_if.reg_rdata[7];
            cnt_d    = 3'd0;
            state_d  = READ;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_i2c_target.sv
// Bench for cpu_i2c_target: an I2C initiator model drives transactions while a
// transaction-level model predicts ACKs, register writes, read bytes and pointer.
module tb_cpu_i2c_target;
  localparam int Q = 4;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic scl        = 1'b1;
  logic tb_sda_low = 1'b0;
  wire  sda_bus;

  pullup (sda_bus);
  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  cpu_i2c_target_if #(.PTR_WIDTH(8)) rif ();

  cpu_i2c_target #(.ADDRESS(7'h50), .PTR_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i2c_scl (scl),
    .i2c_sda (sda_bus),
    .reg_if  (rif)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  // Register bank on the CPU side plus bus monitors.
  logic [7:0]  bank [256];
  bit          bank_init = 1'b0;
  wr_t         got_wr [$];
  int unsigned cyc      = 0;
  int unsigned dut_low  = 0;
  int unsigned busy_cnt = 0;
  int unsigned wr_long  = 0;
  logic        wr_prev  = 1'b0;

  assign rif.reg_rdata = bank[rif.reg_address];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 256; i++) bank[i] <= 8'(i + 1);
      bank_init <= 1'b1;
    end else if (rif.reg_write) begin
      bank[rif.reg_address] <= rif.reg_wdata;
    end
    if (rif.reg_write) got_wr.push_back('{addr: rif.reg_address, data: rif.reg_wdata, cyc: cyc});
    if (rif.reg_write && wr_prev) wr_long <= wr_long + 1;
    wr_prev <= rif.reg_write;
    if (!sda_bus && !tb_sda_low) dut_low <= dut_low + 1;
    if (rif.busy) busy_cnt <= busy_cnt + 1;
  end

  // Reference model state
  logic [7:0] emem [256];
  logic [7:0] mptr;
  wr_t        exp_wr [$];
  int         wr_rd    = 0;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] wdat [4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl) begin
      tb_sda_low = 1'b0; wclk(2 * Q); scl = 1'b1; wclk(Q);
    end
    tb_sda_low = 1'b1; wclk(Q); scl = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); tb_sda_low = 1'b0; wclk(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [31:0] last_rise);
    last_rise = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      wclk(Q); tb_sda_low = ~b[i]; wclk(Q); scl = 1'b1;
      last_rise = cyc;
      wclk(2 * Q); scl = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack, output logic [31:0] rise8);
    send_bits(b, 8, rise8);
    wclk(Q); tb_sda_low = 1'b0; wclk(Q); scl = 1'b1; wclk(Q); ack = sda_bus; wclk(Q); scl = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wclk(2 * Q); scl = 1'b1; wclk(Q); b[i] = sda_bus; wclk(Q); scl = 1'b0;
    end
    wclk(Q); tb_sda_low = ~nack; wclk(Q); scl = 1'b1; wclk(2 * Q); scl = 1'b0;
    wclk(1); tb_sda_low = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    wr_t e;
    check_val({tag, "_nwr"}, 32'(got_wr.size() - wr_rd), 32'(exp_wr.size()));
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      if (wr_rd < got_wr.size()) begin
        check_val({tag, "_waddr"}, 32'(got_wr[wr_rd].addr), 32'(e.addr));
        check_val({tag, "_wdata"}, 32'(got_wr[wr_rd].data), 32'(e.data));
        check_val({tag, "_wlat"},  got_wr[wr_rd].cyc, e.cyc);
        wr_rd++;
      end
    end
    wr_rd = got_wr.size();
  endtask

  task automatic write_txn(input logic [6:0] a7, input logic [7:0] ptr, input int nd, input string tag);
    logic        ack;
    logic [31:0] r8;
    logic        hit;
    int unsigned low0, busy0;
    hit   = (a7 == 7'h50);
    low0  = dut_low;
    busy0 = busy_cnt;
    i2c_start();
    write_byte({a7, 1'b0}, ack, r8);
    check_val({tag, "_aack"}, 32'(ack), hit ? 32'd0 : 32'd1);
    if (hit) check_val({tag, "_busy"}, 32'(rif.busy), 32'd1);
    write_byte(ptr, ack, r8);
    check_val({tag, "_pack"}, 32'(ack), hit ? 32'd0 : 32'd1);
    if (hit) mptr = ptr;
    for (int i = 0; i < nd; i++) begin
      write_byte(wdat[i], ack, r8);
      check_val({tag, "_dack"}, 32'(ack), hit ? 32'd0 : 32'd1);
      if (hit) begin
        exp_wr.push_back('{addr: mptr, data: wdat[i], cyc: r8 + 32'd3});
        emem[mptr] = wdat[i];
        mptr = mptr + 8'd1;
      end
    end
    i2c_stop();
    compare_writes(tag);
    check_val({tag, "_ptr"}, 32'(rif.reg_address), 32'(mptr));
    check_val({tag, "_busy_end"}, 32'(rif.busy), 32'd0);
    if (!hit) begin
      check_val({tag, "_sda_low"}, dut_low - low0, 32'd0);
      check_val({tag, "_busy_seen"}, busy_cnt - busy0, 32'd0);
    end
  endtask

  task automatic read_txn(input logic [7:0] ptr, input logic set_ptr, input int nr, input string tag);
    logic        ack;
    logic [31:0] r8;
    logic [7:0]  b;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hA0, ack, r8);
      check_val({tag, "_wack"}, 32'(ack), 32'd0);
      write_byte(ptr, ack, r8);
      check_val({tag, "_pack"}, 32'(ack), 32'd0);
      mptr = ptr;
      i2c_start();
    end
    write_byte(8'hA1, ack, r8);
    check_val({tag, "_rack"}, 32'(ack), 32'd0);
    for (int i = 0; i < nr; i++) begin
      read_byte(i == nr - 1, b);
      check_val({tag, "_rdata"}, 32'(b), 32'(emem[mptr]));
      mptr = mptr + 8'd1;
    end
    i2c_stop();
    compare_writes(tag);
    check_val({tag, "_ptr"}, 32'(rif.reg_address), 32'(mptr));
    check_val({tag, "_busy_end"}, 32'(rif.busy), 32'd0);
  endtask

  initial begin
    logic        ack;
    logic [31:0] r8;
    int          kind;
    logic [7:0]  p;

    for (int i = 0; i < 256; i++) emem[i] = 8'(i + 1);
    mptr = 8'd0;

    wclk(4);
    check_val("rst_sda",   32'(sda_bus), 32'd1);
    check_val("rst_addr",  32'(rif.reg_address), 32'd0);
    check_val("rst_wdata", 32'(rif.reg_wdata), 32'd0);
    check_val("rst_write", 32'(rif.reg_write), 32'd0);
    check_val("rst_busy",  32'(rif.busy), 32'd0);
    reset_n = 1'b1;
    wclk(4);

    wdat[0] = 8'h55; wdat[1] = 8'h66;
    write_txn(7'h50, 8'h10, 2, "wr");
    read_txn(8'h20, 1'b1, 3, "rd");
    write_txn(7'h51, 8'h00, 0, "nomatch");

    wdat[0] = 8'hAA; wdat[1] = 8'hBB;
    write_txn(7'h50, 8'hFF, 2, "wrap");
    read_txn(8'hFF, 1'b1, 2, "wraprd");

    // Data byte cut short by STOP after four bits
    i2c_start();
    write_byte(8'hA0, ack, r8);
    check_val("abort_aack", 32'(ack), 32'd0);
    write_byte(8'h05, ack, r8);
    check_val("abort_pack", 32'(ack), 32'd0);
    mptr = 8'h05;
    send_bits(8'h12, 4, r8);
    i2c_stop();
    compare_writes("abort");
    check_val("abort_ptr",  32'(rif.reg_address), 32'(mptr));
    check_val("abort_busy", 32'(rif.busy), 32'd0);
    check_val("abort_sda",  32'(sda_bus), 32'd1);

    // Reset while the target holds SDA low for a read data bit
    i2c_start();
    write_byte(8'hA0, ack, r8);
    write_byte(8'h30, ack, r8);
    i2c_start();
    write_byte(8'hA1, ack, r8);
    check_val("mrst_rack", 32'(ack), 32'd0);
    wclk(4);
    check_val("mrst_drive", 32'(sda_bus), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check_val("mrst_sda",   32'(sda_bus), 32'd1);
    check_val("mrst_addr",  32'(rif.reg_address), 32'd0);
    check_val("mrst_wdata", 32'(rif.reg_wdata), 32'd0);
    check_val("mrst_write", 32'(rif.reg_write), 32'd0);
    check_val("mrst_busy",  32'(rif.busy), 32'd0);
    mptr = 8'd0;
    wclk(3);
    reset_n = 1'b1;
    wclk(3);
    wdat[0] = 8'h3C; wdat[1] = 8'hC3;
    write_txn(7'h50, 8'h40, 2, "postrst");

    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 2));
      p = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(8'hFC + 8'($urandom_range(0, 3)));
      for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
      case (kind)
        0:       write_txn(7'h50, p, int'($urandom_range(0, 3)), "rnd_wr");
        1:       write_txn(7'($urandom_range(0, 127)), p, int'($urandom_range(0, 2)), "rnd_addr");
        default: read_txn(p, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), "rnd_rd");
      endcase
    end

    check_val("wr_pulse_width", wr_long, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
